// File: rtl/branch_predict_unit_pkg.sv
// Shared definitions for the branch prediction unit.
//   - br_type_e : EX-stage branch type encodings (codes 3'd7 is undefined)
//   - CNT_*     : 2-bit saturating counter states of the BHT
//   - helpers   : saturating counter step functions
package branch_predict_unit_pkg;

  typedef enum logic [2:0] {
    NOBRANCH = 3'd0,
    BEQ      = 3'd1,
    BNE      = 3'd2,
    BLT      = 3'd3,
    BGE      = 3'd4,
    BLTU     = 3'd5,
    BGEU     = 3'd6
  } br_type_e;

  localparam logic [1:0] CNT_SNT = 2'b00;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_WT  = 2'b10;
  localparam logic [1:0] CNT_ST  = 2'b11;

  // Counter step towards strongly-taken, holding at the top.
  function automatic logic [1:0] cnt_inc(input logic [1:0] c);
    return (c == CNT_ST) ? CNT_ST : c + 2'd1;
  endfunction

  // Counter step towards strongly-not-taken, holding at the bottom.
  function automatic logic [1:0] cnt_dec(input logic [1:0] c);
    return (c == CNT_SNT) ? CNT_SNT : c - 2'd1;
  endfunction

  // 32-bit increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/branch_predict_unit_cond.sv
// Combinational branch condition evaluator.
//   i_reg1, i_reg2 : XLEN-wide operands
//   i_br_type      : branch type (br_type_e encoding)
//   o_br           : condition true; 0 for NOBRANCH and undefined codes
module branch_cond
  import branch_predict_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_reg1,
  input  logic [XLEN-1:0] i_reg2,
  input  logic [2:0]      i_br_type,
  output logic            o_br
);

  logic w_eq;
  logic w_lt_s;
  logic w_lt_u;

  assign w_eq   = (i_reg1 == i_reg2);
  assign w_lt_s = ($signed(i_reg1) < $signed(i_reg2));
  assign w_lt_u = (i_reg1 < i_reg2);

  // Select the comparison that matches the branch type
  always_comb begin
    o_br = 1'b0;
    case (i_br_type)
      BEQ:     o_br = w_eq;
      BNE:     o_br = !w_eq;
      BLT:     o_br = w_lt_s;
      BGE:     o_br = !w_lt_s;
      BLTU:    o_br = w_lt_u;
      BGEU:    o_br = !w_lt_u;
      default: o_br = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch prediction unit: direct-mapped BTB + 2-bit BHT for IF-stage
// next-PC prediction, EX-stage branch resolution and saturating stats.
//   clk, rst_n          : clock, async active-low reset
//   i_if_pc             : fetch PC; o_pred_taken / o_pred_target predict it
//   i_ex_*              : EX instruction, operands, type, target and the
//                         prediction that was made for it in IF
//   o_br                : actual outcome
//   o_mispredict        : flush request; o_redirect_pc is the correct next PC
//   i_stat_clr          : synchronous clear of o_br_cnt / o_miss_cnt
module branch_predict_unit
  import branch_predict_unit_pkg::*;
#(
  parameter int         XLEN     = 32,
  parameter int         ENTRIES  = 64,
  parameter logic [1:0] CNT_INIT = 2'b01
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] i_if_pc,
  output logic            o_pred_taken,
  output logic [XLEN-1:0] o_pred_target,
  input  logic            i_ex_valid,
  input  logic            i_ex_stall,
  input  logic [XLEN-1:0] i_ex_pc,
  input  logic [XLEN-1:0] i_ex_reg1,
  input  logic [XLEN-1:0] i_ex_reg2,
  input  logic [2:0]      i_ex_br_type,
  input  logic [XLEN-1:0] i_ex_target,
  input  logic            i_ex_pred_taken,
  input  logic [XLEN-1:0] i_ex_pred_target,
  output logic            o_br,
  output logic            o_mispredict,
  output logic [XLEN-1:0] o_redirect_pc,
  input  logic            i_stat_clr,
  output logic [31:0]     o_br_cnt,
  output logic [31:0]     o_miss_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(32'd4);

  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  logic [XLEN-1:0]    r_target [ENTRIES];
  logic [1:0]         r_cnt    [ENTRIES];
  logic [31:0]        r_br_cnt;
  logic [31:0]        r_miss_cnt;

  logic [IDX_W-1:0] w_if_idx;
  logic [TAG_W-1:0] w_if_tag;
  logic             w_if_hit;
  logic [IDX_W-1:0] w_ex_idx;
  logic [TAG_W-1:0] w_ex_tag;
  logic             w_ex_hit;
  logic             w_cond;
  logic             w_is_br;
  logic             w_upd;

  // Predict: reads the table contents as they stand before any EX write
  // this cycle, so a same-index update is only visible next cycle.
  assign w_if_idx      = i_if_pc[IDX_W+1:2];
  assign w_if_tag      = i_if_pc[XLEN-1:IDX_W+2];
  assign w_if_hit      = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
  assign o_pred_taken  = w_if_hit && r_cnt[w_if_idx][1];
  assign o_pred_target = o_pred_taken ? r_target[w_if_idx] : i_if_pc + PC_STEP;

  branch_cond #(.XLEN(XLEN)) u_cond (
    .i_reg1    (i_ex_reg1),
    .i_reg2    (i_ex_reg2),
    .i_br_type (i_ex_br_type),
    .o_br      (w_cond)
  );

  // Resolve: a bubble in EX never produces a taken outcome or a flush.
  assign w_is_br       = (i_ex_br_type != NOBRANCH);
  assign o_br          = i_ex_valid && w_cond;
  assign o_redirect_pc = o_br ? i_ex_target : i_ex_pc + PC_STEP;
  assign o_mispredict  = i_ex_valid && w_is_br &&
                         ((i_ex_pred_taken != o_br) ||
                          (o_br && (i_ex_pred_target != i_ex_target)));

  assign w_upd    = i_ex_valid && !i_ex_stall && w_is_br;
  assign w_ex_idx = i_ex_pc[IDX_W+1:2];
  assign w_ex_tag = i_ex_pc[XLEN-1:IDX_W+2];
  assign w_ex_hit = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);

  // BTB/BHT training: strengthen or allocate on taken, weaken on not-taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= {TAG_W{1'b0}};
        r_target[i] <= {XLEN{1'b0}};
        r_cnt[i]    <= CNT_INIT;
      end
    end else if (w_upd) begin
      if (o_br) begin
        if (w_ex_hit) begin
          r_cnt[w_ex_idx]    <= cnt_inc(r_cnt[w_ex_idx]);
          r_target[w_ex_idx] <= i_ex_target;
        end else begin
          // New or aliasing branch: take over the entry as weakly taken.
          r_valid[w_ex_idx]  <= 1'b1;
          r_tag[w_ex_idx]    <= w_ex_tag;
          r_target[w_ex_idx] <= i_ex_target;
          r_cnt[w_ex_idx]    <= CNT_WT;
        end
      end else if (w_ex_hit) begin
        r_cnt[w_ex_idx] <= cnt_dec(r_cnt[w_ex_idx]);
      end
    end
  end

  // Saturating statistics; clear wins over a same-cycle increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_br_cnt   <= 32'd0;
      r_miss_cnt <= 32'd0;
    end else if (i_stat_clr) begin
      r_br_cnt   <= 32'd0;
      r_miss_cnt <= 32'd0;
    end else begin
      if (w_upd) begin
        r_br_cnt <= sat_inc32(r_br_cnt);
      end
      if (w_upd && o_mispredict) begin
        r_miss_cnt <= sat_inc32(r_miss_cnt);
      end
    end
  end

  assign o_br_cnt   = r_br_cnt;
  assign o_miss_cnt = r_miss_cnt;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: directed scenarios followed
// by randomized traffic, all compared against a table-level reference model.
module tb_branch_predict_unit;
  import branch_predict_unit_pkg::*;

  localparam int ENTRIES = 64;
  localparam int IDX_W   = 6;
  localparam longint MAX32 = 64'hFFFF_FFFF;

  logic        clk;
  logic        rst_n;
  logic [31:0] i_if_pc;
  logic        o_pred_taken;
  logic [31:0] o_pred_target;
  logic        i_ex_valid;
  logic        i_ex_stall;
  logic [31:0] i_ex_pc;
  logic [31:0] i_ex_reg1;
  logic [31:0] i_ex_reg2;
  logic [2:0]  i_ex_br_type;
  logic [31:0] i_ex_target;
  logic        i_ex_pred_taken;
  logic [31:0] i_ex_pred_target;
  logic        o_br;
  logic        o_mispredict;
  logic [31:0] o_redirect_pc;
  logic        i_stat_clr;
  logic [31:0] o_br_cnt;
  logic [31:0] o_miss_cnt;

  branch_predict_unit #(.XLEN(32), .ENTRIES(ENTRIES), .CNT_INIT(2'b01)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_if_pc          (i_if_pc),
    .o_pred_taken     (o_pred_taken),
    .o_pred_target    (o_pred_target),
    .i_ex_valid       (i_ex_valid),
    .i_ex_stall       (i_ex_stall),
    .i_ex_pc          (i_ex_pc),
    .i_ex_reg1        (i_ex_reg1),
    .i_ex_reg2        (i_ex_reg2),
    .i_ex_br_type     (i_ex_br_type),
    .i_ex_target      (i_ex_target),
    .i_ex_pred_taken  (i_ex_pred_taken),
    .i_ex_pred_target (i_ex_pred_target),
    .o_br             (o_br),
    .o_mispredict     (o_mispredict),
    .o_redirect_pc    (o_redirect_pc),
    .i_stat_clr       (i_stat_clr),
    .o_br_cnt         (o_br_cnt),
    .o_miss_cnt       (o_miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  bit          m_valid  [ENTRIES];
  logic [31:0] m_tag    [ENTRIES];
  logic [31:0] m_target [ENTRIES];
  int          m_cnt    [ENTRIES];
  longint      m_br_cnt;
  longint      m_miss_cnt;

  // Outputs sampled in the last step, for scenario-specific checks
  bit          obs_ptk, obs_br, obs_mis;
  logic [31:0] obs_ptgt, obs_redir;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = 32'd0; m_target[i] = 32'd0; m_cnt[i] = 1;
    end
    m_br_cnt = 0; m_miss_cnt = 0;
  endfunction

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic logic [31:0] m_tagof(input logic [31:0] pc);
    return pc / (4 * ENTRIES);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == m_tagof(pc));
  endfunction

  function automatic bit m_pred(input logic [31:0] pc);
    return m_hit(pc) && (m_cnt[m_idx(pc)] >= 2);
  endfunction

  function automatic logic [31:0] m_pred_tgt(input logic [31:0] pc);
    return m_pred(pc) ? m_target[m_idx(pc)] : pc + 32'd4;
  endfunction

  function automatic bit m_cond(input logic [2:0] t, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = longint'(a);          ub = longint'(b);
    case (t)
      3'd1:    return ua == ub;
      3'd2:    return ua != ub;
      3'd3:    return sa < sb;
      3'd4:    return sa >= sb;
      3'd5:    return ua < ub;
      3'd6:    return ua >= ub;
      default: return 1'b0;
    endcase
  endfunction

  // One cycle: drive after a falling edge, check combinational outputs,
  // clock, advance the model and check the statistics.
  task automatic step(input logic [31:0] ifpc, input bit v, input bit st,
                      input logic [31:0] epc, input logic [31:0] r1, input logic [31:0] r2,
                      input logic [2:0] bt, input logic [31:0] tgt,
                      input bit ptk, input logic [31:0] ptgt, input bit clr);
    bit e_ptk, e_br, e_mis, upd, hit;
    logic [31:0] e_ptgt, e_redir;
    int ix;
    i_if_pc = ifpc; i_ex_valid = v; i_ex_stall = st; i_ex_pc = epc;
    i_ex_reg1 = r1; i_ex_reg2 = r2; i_ex_br_type = bt; i_ex_target = tgt;
    i_ex_pred_taken = ptk; i_ex_pred_target = ptgt; i_stat_clr = clr;
    #1;
    e_ptk   = m_pred(ifpc);
    e_ptgt  = m_pred_tgt(ifpc);
    e_br    = v && m_cond(bt, r1, r2);
    e_redir = e_br ? tgt : epc + 32'd4;
    e_mis   = v && (bt != 3'd0) && ((ptk != e_br) || (e_br && ptgt != tgt));
    check_val("pred_taken", o_pred_taken, e_ptk);
    check_val("pred_target", o_pred_target, e_ptgt);
    check_val("br", o_br, e_br);
    check_val("redirect_pc", o_redirect_pc, e_redir);
    check_val("mispredict", o_mispredict, e_mis);
    obs_ptk = o_pred_taken; obs_ptgt = o_pred_target; obs_br = o_br;
    obs_mis = o_mispredict; obs_redir = o_redirect_pc;
    upd = v && !st && (bt != 3'd0);
    hit = m_hit(epc);
    ix  = m_idx(epc);
    @(posedge clk);
    #1;
    if (upd) begin
      if (e_br) begin
        if (hit) begin
          m_cnt[ix] = (m_cnt[ix] < 3) ? m_cnt[ix] + 1 : 3;
          m_target[ix] = tgt;
        end else begin
          m_valid[ix] = 1'b1; m_tag[ix] = m_tagof(epc); m_target[ix] = tgt; m_cnt[ix] = 2;
        end
      end else if (hit) begin
        m_cnt[ix] = (m_cnt[ix] > 0) ? m_cnt[ix] - 1 : 0;
      end
    end
    if (clr) begin
      m_br_cnt = 0; m_miss_cnt = 0;
    end else begin
      if (upd && m_br_cnt < MAX32) m_br_cnt++;
      if (upd && e_mis && m_miss_cnt < MAX32) m_miss_cnt++;
    end
    check_val("br_cnt", o_br_cnt, m_br_cnt[31:0]);
    check_val("miss_cnt", o_miss_cnt, m_miss_cnt[31:0]);
    @(negedge clk);
  endtask

  task automatic idle(input logic [31:0] ifpc);
    step(ifpc, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 3'd0, 32'd0, 1'b0, 32'd0, 1'b0);
  endtask

  initial begin
    longint miss0;
    logic [31:0] pool [8];
    pool[0] = 32'h100; pool[1] = 32'h104; pool[2] = 32'h200; pool[3] = 32'h300;
    pool[4] = 32'h1100; pool[5] = 32'h2000; pool[6] = 32'h2004; pool[7] = 32'h40;

    rst_n = 1'b0; i_if_pc = 32'h100; i_ex_valid = 1'b0; i_ex_stall = 1'b0;
    i_ex_pc = 32'd0; i_ex_reg1 = 32'd0; i_ex_reg2 = 32'd0; i_ex_br_type = 3'd0;
    i_ex_target = 32'd0; i_ex_pred_taken = 1'b0; i_ex_pred_target = 32'd0; i_stat_clr = 1'b0;
    m_reset();
    #12;
    check_val("rst_pred_taken", o_pred_taken, 1'b0);
    check_val("rst_pred_target", o_pred_target, 32'h104);
    check_val("rst_br", o_br, 1'b0);
    check_val("rst_mispredict", o_mispredict, 1'b0);
    check_val("rst_br_cnt", o_br_cnt, 32'd0);
    check_val("rst_miss_cnt", o_miss_cnt, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // First BEQ: unknown branch, taken -> mispredict and allocate
    step(32'h100, 1'b1, 1'b0, 32'h100, 32'd5, 32'd5, BEQ, 32'h80, 1'b0, 32'h104, 1'b0);
    check_val("beq_br", obs_br, 1'b1);
    check_val("beq_mis", obs_mis, 1'b1);
    check_val("beq_redir", obs_redir, 32'h80);
    check_val("beq_br_cnt", o_br_cnt, 32'd1);
    check_val("beq_miss_cnt", o_miss_cnt, 32'd1);
    idle(32'h100);
    check_val("beq_now_taken", obs_ptk, 1'b1);
    check_val("beq_now_target", obs_ptgt, 32'h80);

    // Signed vs unsigned compare on the same operands
    step(32'h0, 1'b1, 1'b0, 32'h300, 32'hFFFF_FFFF, 32'd1, BLT, 32'h400, 1'b0, 32'h304, 1'b0);
    check_val("blt_neg", obs_br, 1'b1);
    step(32'h0, 1'b1, 1'b0, 32'h304, 32'hFFFF_FFFF, 32'd1, BLTU, 32'h400, 1'b0, 32'h308, 1'b0);
    check_val("bltu_big", obs_br, 1'b0);

    // Loop branch at 0x200: allocate, then T,T,T,N,T; only N mispredicts
    step(32'h200, 1'b1, 1'b0, 32'h200, 32'd1, 32'd2, BNE, 32'h180, m_pred(32'h200), m_pred_tgt(32'h200), 1'b0);
    miss0 = m_miss_cnt;
    begin
      bit outc [5];
      outc[0] = 1'b1; outc[1] = 1'b1; outc[2] = 1'b1; outc[3] = 1'b0; outc[4] = 1'b1;
      for (int k = 0; k < 5; k++) begin
        step(32'h200, 1'b1, 1'b0, 32'h200, 32'd1, outc[k] ? 32'd2 : 32'd1, BNE, 32'h180,
             m_pred(32'h200), m_pred_tgt(32'h200), 1'b0);
        check_val("loop_pred_taken", obs_ptk, 1'b1);
        check_val("loop_mis", obs_mis, !outc[k]);
      end
    end
    check_val("loop_miss_delta", o_miss_cnt, miss0[31:0] + 32'd1);

    // Stalled mispredicting BNE: flags follow inputs, no state change
    step(32'h500, 1'b1, 1'b1, 32'h500, 32'd3, 32'd4, BNE, 32'h600, 1'b0, 32'h504, 1'b0);
    check_val("stall_mis", obs_mis, 1'b1);
    idle(32'h500);
    check_val("stall_no_alloc", obs_ptk, 1'b0);
    step(32'h500, 1'b1, 1'b0, 32'h500, 32'd3, 32'd4, BNE, 32'h600, 1'b0, 32'h504, 1'b0);
    idle(32'h500);
    check_val("unstall_alloc", obs_ptk, 1'b1);
    check_val("unstall_target", obs_ptgt, 32'h600);

    // Alias pair 0x100 / 0x100 + 4*ENTRIES share an index
    step(32'h0, 1'b1, 1'b0, 32'h100, 32'd7, 32'd7, BEQ, 32'h90, m_pred(32'h100), m_pred_tgt(32'h100), 1'b0);
    step(32'h0, 1'b1, 1'b0, 32'h200, 32'd7, 32'd7, BEQ, 32'h700, m_pred(32'h200), m_pred_tgt(32'h200), 1'b0);
    idle(32'h100);
    check_val("alias_first_miss", obs_ptk, 1'b0);
    idle(32'h200);
    check_val("alias_second_hit", obs_ptk, 1'b1);
    check_val("alias_second_tgt", obs_ptgt, 32'h700);

    // Statistics saturation and clear priority
    force dut.r_br_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_br_cnt;
    m_br_cnt = MAX32;
    step(32'h0, 1'b1, 1'b0, 32'h800, 32'd1, 32'd1, BEQ, 32'h900, 1'b0, 32'h804, 1'b0);
    check_val("sat_hold", o_br_cnt, 32'hFFFF_FFFF);
    step(32'h0, 1'b1, 1'b0, 32'h800, 32'd1, 32'd1, BEQ, 32'h900, 1'b0, 32'h804, 1'b1);
    check_val("clr_br_cnt", o_br_cnt, 32'd0);
    check_val("clr_miss_cnt", o_miss_cnt, 32'd0);

    // Randomized traffic with one asynchronous reset in the middle
    for (int n = 0; n < 400; n++) begin
      logic [31:0] epc, ipc, a, b;
      logic [2:0] bt;
      bit ptk;
      logic [31:0] ptgt;
      if (n == 200) begin
        #2;
        rst_n = 1'b0;
        #1;
        m_reset();
        check_val("midrst_pred", o_pred_taken, 1'b0);
        check_val("midrst_br_cnt", o_br_cnt, 32'd0);
        check_val("midrst_miss_cnt", o_miss_cnt, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(32'h200);
        check_val("midrst_first_pred", obs_ptk, 1'b0);
      end
      epc = pool[$urandom_range(0, 7)];
      ipc = pool[$urandom_range(0, 7)];
      a   = $urandom;
      b   = ($urandom_range(0, 2) == 0) ? a : $urandom;
      bt  = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) < 7) begin
        ptk = m_pred(epc); ptgt = m_pred_tgt(epc);
      end else begin
        ptk = 1'($urandom_range(0, 1)); ptgt = pool[$urandom_range(0, 7)];
      end
      step(ipc, $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 2, epc, a, b, bt,
           pool[$urandom_range(0, 7)] + 32'h10, ptk, ptgt, $urandom_range(0, 49) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
